butterfly_unit: RTL and testbench

Radix-2 add/subtract butterfly stage directly upstream of the saturation/limiter stage in the FFT datapath. Accepts one pair of signed `width`-bit operands per input handshake, computes full-precision sum and difference at `width+1` bits, and emits them as two consecutive AXI-stream beats (sum first, then difference) for the limiter to clamp back to `width` bits. Tracks pairs per frame against the configured FFT size and flags framing errors.

---
 rtl/butterfly_unit.sv | 180 ++++++++++++++++++
 tb/tb_butterfly_unit.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/butterfly_unit.sv
// butterfly_unit
//   Radix-2 add/subtract butterfly. Each accepted input pair {a, b} produces
//   two output beats on an AXI-stream style port: a+b first, then a-b, both at
//   full precision (width+1 bits). The downstream limiter clamps them back.
//   Pairs are counted per frame against the FFT size; a frame that closes on
//   the wrong pair (early or missing s_tlast) raises a one-cycle frame_err.
//
// Ports
//   clk        clock, rising edge
//   rst        synchronous active-high reset
//   s_tvalid   input pair valid
//   s_tready   input ready (combinational from state and m_tready)
//   s_tlast    last pair of a frame
//   data_i     {a, b}, two's complement, a in the upper half
//   m_tvalid   output beat valid
//   m_tready   downstream ready
//   m_tlast    last beat of a frame (carried on the difference beat)
//   data_o     signed sum or difference, width+1 bits
//   pair_cnt   pairs accepted so far in the current frame
//   frame_err  one-cycle pulse after a mis-framed pair is accepted

module butterfly_unit #(
    parameter int width = 8,
    parameter int N     = 16,
    localparam int CW   = $clog2(N / 2)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    s_tvalid,
    output logic                    s_tready,
    input  logic                    s_tlast,
    input  logic [2*width-1:0]      data_i,
    output logic                    m_tvalid,
    input  logic                    m_tready,
    output logic                    m_tlast,
    output logic signed [width:0]   data_o,
    output logic [CW-1:0]           pair_cnt,
    output logic                    frame_err
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        SUM   = 2'd1,
        DIFF  = 2'd2
    } state_t;

    localparam logic [CW-1:0] LAST_IDX = CW'(N / 2 - 1);

    state_t state, state_n;

    logic signed [width-1:0] a_p0;
    logic signed [width-1:0] b_p0;
    logic signed [width:0]   diff_p1;
    logic                    tlast_p1;
    logic                    accept;
    logic                    at_last_idx;

    // Sign-extend both operands before adding so the carry/borrow lands in
    // the extra bit; the result can never overflow width+1 bits.
    function automatic logic signed [width:0] bf_sum(
        input logic signed [width-1:0] a,
        input logic signed [width-1:0] b
    );
        logic signed [width:0] ax;
        logic signed [width:0] bx;
        ax = a;
        bx = b;
        return ax + bx;
    endfunction

    function automatic logic signed [width:0] bf_diff(
        input logic signed [width-1:0] a,
        input logic signed [width-1:0] b
    );
        logic signed [width:0] ax;
        logic signed [width:0] bx;
        ax = a;
        bx = b;
        return ax - bx;
    endfunction

    assign a_p0        = data_i[2*width-1:width];
    assign b_p0        = data_i[width-1:0];
    assign accept      = s_tvalid && s_tready;
    assign at_last_idx = (pair_cnt == LAST_IDX);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= EMPTY;
        end else begin
            state <= state_n;
        end
    end

    // Next-state logic; a new pair can be taken in DIFF on the same edge the
    // difference beat leaves, which gives one beat per cycle with no bubble.
    always_comb begin
        state_n = state;
        unique case (state)
            EMPTY: if (accept) state_n = SUM;
            SUM:   if (m_tready) state_n = DIFF;
            DIFF: begin
                if (m_tready) begin
                    state_n = accept ? SUM : EMPTY;
                end
            end
            default: state_n = EMPTY;
        endcase
    end

    // Output/handshake decode; s_tready is held low during reset so nothing
    // is taken on the reset edge.
    always_comb begin
        m_tvalid = 1'b0;
        s_tready = 1'b0;
        unique case (state)
            EMPTY: begin
                m_tvalid = 1'b0;
                s_tready = !rst;
            end
            SUM: begin
                m_tvalid = 1'b1;
                s_tready = 1'b0;
            end
            DIFF: begin
                m_tvalid = 1'b1;
                s_tready = !rst && m_tready;
            end
            default: begin
                m_tvalid = 1'b0;
                s_tready = 1'b0;
            end
        endcase
    end

    // Stage p0 -> p1: the difference and frame marker wait here while the
    // sum is on the output.
    always_ff @(posedge clk) begin
        if (accept) begin
            diff_p1  <= bf_diff(a_p0, b_p0);
            tlast_p1 <= s_tlast;
        end
    end

    // Output beat register: sum on acceptance, difference after the sum
    // handshake, otherwise held.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_o  <= '0;
            m_tlast <= 1'b0;
        end else if (accept) begin
            data_o  <= bf_sum(a_p0, b_p0);
            m_tlast <= 1'b0;
        end else if (state == SUM && m_tready) begin
            data_o  <= diff_p1;
            m_tlast <= tlast_p1;
        end
    end

    // Frame tracking: the frame closes on s_tlast or on the N/2-th pair,
    // whichever comes first; a mismatch between the two is a framing error.
    always_ff @(posedge clk) begin
        if (rst) begin
            pair_cnt  <= '0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            if (accept) begin
                frame_err <= (s_tlast != at_last_idx);
                if (s_tlast || at_last_idx) begin
                    pair_cnt <= '0;
                end else begin
                    pair_cnt <= pair_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_butterfly_unit.sv
module tb_butterfly_unit;

    localparam int W  = 8;
    localparam int N  = 16;
    localparam int CW = $clog2(N / 2);

    logic              clk = 1'b0;
    logic              rst;
    logic              s_tvalid;
    logic              s_tready;
    logic              s_tlast;
    logic [2*W-1:0]    data_i;
    logic              m_tvalid;
    logic              m_tready;
    logic              m_tlast;
    logic [W:0]        data_o;
    logic [CW-1:0]     pair_cnt;
    logic              frame_err;

    butterfly_unit #(.width(W), .N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .s_tvalid  (s_tvalid),
        .s_tready  (s_tready),
        .s_tlast   (s_tlast),
        .data_i    (data_i),
        .m_tvalid  (m_tvalid),
        .m_tready  (m_tready),
        .m_tlast   (m_tlast),
        .data_o    (data_o),
        .pair_cnt  (pair_cnt),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Expected beats not yet emitted: {last, data}. The unit buffers one pair.
    logic [W+1:0] q[$];
    int           mcnt;
    logic         merr;
    logic         mon_en = 1'b0;
    int           err_pulses = 0;
    int           ma, mb;
    logic         at_end;
    logic         prev_hold = 1'b0;
    logic [W:0]   prev_data;
    logic         prev_last;

    always @(negedge clk) begin
        if (mon_en) begin
            if (rst) chk("s_tready_rst", s_tready, 0);
            else     chk("s_tready", s_tready,
                         (q.size() == 0) || (q.size() == 1 && m_tready));
            chk("m_tvalid", m_tvalid, q.size() != 0);
            if (m_tvalid && q.size() != 0) begin
                chk("data_o", data_o, q[0][W:0]);
                chk("m_tlast", m_tlast, q[0][W+1]);
            end
            chk("pair_cnt", pair_cnt, mcnt);
            chk("frame_err", frame_err, merr);
            if (frame_err) err_pulses++;
            if (prev_hold) begin
                chk("hold_valid", m_tvalid, 1);
                chk("hold_data", data_o, prev_data);
                chk("hold_last", m_tlast, prev_last);
            end
            prev_hold = m_tvalid && !m_tready && !rst;
            prev_data = data_o;
            prev_last = m_tlast;

            if (rst) begin
                q.delete();
                mcnt = 0;
                merr = 1'b0;
            end else begin
                merr = 1'b0;
                if (m_tvalid && m_tready && q.size() != 0) void'(q.pop_front());
                if (s_tvalid && s_tready) begin
                    ma = $signed(data_i[2*W-1:W]);
                    mb = $signed(data_i[W-1:0]);
                    q.push_back({1'b0, (W+1)'(ma + mb)});
                    q.push_back({s_tlast, (W+1)'(ma - mb)});
                    at_end = (mcnt == N/2 - 1);
                    merr = (s_tlast != at_end);
                    mcnt = (s_tlast || at_end) ? 0 : mcnt + 1;
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer one pair and return 1 time unit after the edge that accepts it.
    task automatic send(input logic [2*W-1:0] d, input logic last);
        int n;
        n = 0;
        s_tvalid = 1'b1;
        data_i   = d;
        s_tlast  = last;
        do begin
            @(negedge clk);
            n++;
        end while (!s_tready && n < 300);
        if (!s_tready) chk("send_timeout", 0, 1);
        @(posedge clk);
        #1;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) step();
        rst = 1'b0;
    endtask

    task automatic lit_pair(input logic signed [W-1:0] a, input logic signed [W-1:0] b,
                            input logic [W:0] es, input logic [W:0] ed);
        send({a, b}, 1'b0);
        @(negedge clk);
        chk("lit_sum", data_o, es);
        @(negedge clk);
        chk("lit_diff", data_o, ed);
        step();
    endtask

    logic rand_on = 1'b0;
    int   pulses0;
    int   idx;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; s_tvalid = 1'b0; s_tlast = 1'b0; data_i = '0; m_tready = 1'b0;
        mcnt = 0; merr = 1'b0;
        repeat (3) step();
        mon_en = 1'b1;
        @(negedge clk);
        chk("rst_m_tvalid", m_tvalid, 0);
        chk("rst_data_o", data_o, 0);
        chk("rst_pair_cnt", pair_cnt, 0);
        chk("rst_frame_err", frame_err, 0);
        chk("rst_m_tlast", m_tlast, 0);
        chk("rst_s_tready", s_tready, 0);
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_s_tready", s_tready, 1);
        step();

        // Literal pins on the arithmetic
        m_tready = 1'b1;
        lit_pair(8'sd127,  8'sd127,  9'h0FE, 9'h000);
        lit_pair(-8'sd128, 8'sd127,  9'h1FF, 9'h101);
        lit_pair(-8'sd128, -8'sd128, 9'h100, 9'h000);
        do_reset();

        // Full-rate frame: s_tvalid held high, m_tready high
        pulses0 = err_pulses;
        idx = 0;
        s_tvalid = 1'b1;
        data_i   = 16'($urandom);
        s_tlast  = 1'b0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            chk("tput_s_tready", s_tready, (i % 2) == 0);
            if (s_tready) begin
                idx++;
                step();
                data_i  = 16'($urandom);
                s_tlast = (idx == 7);
            end else begin
                step();
            end
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        repeat (3) step();
        chk("tput_pairs", idx, 8);
        chk("tput_no_err", err_pulses - pulses0, 0);
        chk("tput_cnt_end", pair_cnt, 0);

        // Early tlast on the 3rd pair
        do_reset();
        send(16'($urandom), 1'b0);
        send(16'($urandom), 1'b0);
        send(16'($urandom), 1'b1);
        @(negedge clk);
        chk("early_err", frame_err, 1);
        chk("early_cnt", pair_cnt, 0);
        step();

        // Missing tlast on the 8th pair
        for (int k = 0; k < 8; k++) send(16'($urandom), 1'b0);
        @(negedge clk);
        chk("miss_err", frame_err, 1);
        chk("miss_cnt", pair_cnt, 0);
        repeat (3) step();

        // Random backpressure over 4 well-formed frames
        do_reset();
        rand_on = 1'b1;
        fork
            begin
                while (rand_on) begin
                    m_tready = 1'($urandom_range(0, 1));
                    step();
                end
            end
            begin
                for (int k = 0; k < 32; k++) begin
                    repeat ($urandom_range(0, 2)) step();
                    send(16'($urandom), (k % 8) == 7);
                end
                for (int t = 0; t < 200 && q.size() != 0; t++) step();
                chk("drain_empty", q.size(), 0);
                rand_on = 1'b0;
            end
        join
        m_tready = 1'b1;
        repeat (2) step();

        // Reset while the sum is stalled
        m_tready = 1'b0;
        send(16'($urandom), 1'b0);
        @(negedge clk);
        chk("stall_valid", m_tvalid, 1);
        step();
        rst = 1'b1;
        step();
        @(negedge clk);
        chk("midrst_valid", m_tvalid, 0);
        chk("midrst_data", data_o, 0);
        chk("midrst_cnt", pair_cnt, 0);
        step();
        rst = 1'b0;
        m_tready = 1'b1;
        lit_pair(8'sd5, 8'sd3, 9'h008, 9'h002);
        @(negedge clk);
        chk("no_stale_valid", m_tvalid, 0);
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
